dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single read/write data port of the on-chip synchronous dual-port RAM between two requesters: port C (CPU load/store unit, normally high priority) and port G (debug/program-loader, low priority).
- Converts byte-addressed, sized requests into word address, byte enables and lane-replicated write data.
- Tracks the RAM's 1-cycle read latency and returns aligned, sign/zero-extended load data to the requester that issued it.
- Sits between the core/debug logic and the RAM data port. The instruction port is not touched.

Parameters:
- ADDR_WIDTH, 15, RAM word-address width. Byte space is 2**(ADDR_WIDTH+2) bytes.
- STARVE_MAX, 8, consecutive cycles port G may be refused before it is forced priority. Range 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- c_valid  in  1  CPU request present
- c_ready  out  1  CPU request accepted this cycle (combinational grant)
- c_addr  in  32  CPU byte address
- c_we  in  1  1 = store, 0 = load
- c_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- c_unsigned  in  1  load zero-extends when 1
- c_wdata  in  32  store data, right-aligned
- c_rsp_valid  out  1  CPU response this cycle
- c_rdata  out  32  extended load data; 0 for stores and errors
- c_err  out  1  response is an error
- g_valid, g_ready, g_addr, g_we, g_size, g_unsigned, g_wdata, g_rsp_valid, g_rdata, g_err: identical set for port G
- ram_addr  out  ADDR_WIDTH  to RAM d_addr
- ram_we  out  1  to RAM d_we
- ram_be  out  4  to RAM d_be; bit0 = byte at offset 0
- ram_wdata  out  32  to RAM d_wdata, little-endian lanes
- ram_rdata  in  32  from RAM d_rdata, valid 1 cycle after the address is presented

Behaviour:
- Grant (combinational, per cycle):
  - force_g = (starve_cnt == STARVE_MAX).
  - If force_g && g_valid: grant G.
  - Otherwise grant C if c_valid, else G if g_valid.
  - At most one of c_ready/g_ready is high. ready is high only when the matching valid is high.
- Starvation counter (starve_cnt, 8 bits):
  - Resets to 0.
  - Increments when g_valid && !g_ready, saturating at STARVE_MAX.
  - Clears to 0 on any g_ready, or when g_valid is low.
- Request decode for the granted request:
  - off = addr[1:0].
  - ram_addr = addr[ADDR_WIDTH+1:2].
- Error conditions (set err):
  - size == 11.
  - Misaligned access: half with off[0] = 1, or word with off != 0.
  - addr[31:ADDR_WIDTH+2] != 0.
  - An errored request is still accepted (ready = 1) but forces ram_we = 0 and ram_be = 0.
- Store lane mapping:
  - Byte: be = 0001 << off, wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 << off, wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata as given.
  - ram_we = granted && we && !err.
- Idle cycles (no grant): ram_we = 0, ram_be = 0. ram_addr and ram_wdata are don't-care but must be stable (hold the last value).
- Response pipeline register, captured on every grant: owner, we, size, unsigned, off, err, plus rsp_pending.
  - Next cycle, rsp_valid = 1 on the owner's port only.
  - Load, no error: select the byte/half at ram_rdata >> (8*off) and extend per size/unsigned. Word passes through.
  - Store or error: rdata = 0. err reflects the captured err.
- Throughput and latency:
  - One request per cycle, back-to-back allowed.
  - Response latency is exactly 1 cycle. There is no response backpressure.
- Reset:
  - All rsp_valid, err, rdata and ram_we low; ready low; starve_cnt = 0; response register cleared.
  - A request accepted in the cycle reset is asserted produces no response.
  - While reset is high, no grant and no RAM write.
- Read-during-write: the store's response carries no data. A load in the next cycle to the same word returns the new data, because the RAM commits the write on the same edge.

Decomposition:
- Package dmem_pkg holds:
  - typedef mem_size_t (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD).
  - struct rsp_ctx_t {owner, we, size, uns, off, err}.
  - Constants OWNER_C = 0, OWNER_G = 1.
- One natural sub-module: dmem_lane_align, a combinational block for store lane/be generation and load extract/extend. It is instantiated once for the store path and once for the load path.

Test Plan:
- RAM word 0 = 0x8899AABB; C loads byte at 0x2 signed -> next cycle c_rsp_valid = 1, c_rdata = 0xFFFFFF99. Same load unsigned -> 0x00000099. Half at 0x2 signed -> 0xFFFF8899.
- C stores byte, addr 0x7, data 0x000000A5 -> same cycle ram_addr = 1, ram_be = 1000, ram_wdata = 0xA5A5A5A5, ram_we = 1. Word-load 0x4 next -> byte 3 = 0xA5, other bytes unchanged.
- C and G both valid continuously, STARVE_MAX = 8 -> G is granted on cycle 9 exactly, then C again. starve_cnt returns to 0. Responses are routed to the correct port with no cross-delivery.
- G half load at 0x3, and C word store at 0x2 -> both accepted, rsp err = 1, rdata = 0, ram_we never asserted, RAM contents unchanged.
- Address 0x0002_0000 with ADDR_WIDTH = 15 -> err = 1, no write.
- Reset asserted in the same cycle C's load is granted -> no c_rsp_valid the following cycle; starve_cnt = 0. The first post-reset request behaves normally with 1-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the access-size encoding, the response context carried across the
// RAM read latency, and the owner tags used to route responses back.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } mem_size_t;

    localparam logic OWNER_C = 1'b0;
    localparam logic OWNER_G = 1'b1;

    // Everything the response stage needs to know about a granted request
    // once the RAM has produced its data one cycle later.
    typedef struct packed {
        logic      owner;
        logic      we;
        mem_size_t size;
        logic      uns;
        logic [1:0] off;
        logic      err;
    } rsp_ctx_t;

    // A half must sit on an even byte, a word on a word boundary.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane helper for the 32-bit little-endian RAM data port.
// In store mode it replicates right-aligned write data across the lanes;
// in load mode it pulls the addressed byte/half out of a RAM word and
// sign/zero-extends it. The byte-enable mask is produced in both modes and
// is forced to zero when the access is not enabled, so callers can use it
// directly as "lanes actually touched".
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        load,
    input  logic        enable,
    input  mem_size_t   size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic [31:0] data_out
);

    logic [3:0]  mask;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [15:0] shifted;

    // Lane mask, replicated store data and extended load data for the given size/offset.
    always_comb begin
        mask       = 4'b0000;
        store_data = data_in;
        load_data  = '0;
        shifted    = 16'(data_in >> {off, 3'b000});
        case (size)
            SZ_BYTE: begin
                mask       = 4'b0001 << off;
                store_data = {4{data_in[7:0]}};
                load_data  = {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mask       = 4'b0011 << off;
                store_data = {2{data_in[15:0]}};
                load_data  = {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                mask       = 4'b1111;
                store_data = data_in;
                load_data  = data_in;
            end
            default: begin
                mask       = 4'b0000;
                store_data = data_in;
                load_data  = '0;
            end
        endcase
        be       = enable ? mask : 4'b0000;
        data_out = load ? load_data : store_data;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the RAM data port between the CPU load/store unit (port C) and the
// debug/program-loader (port G). C normally wins; G is forced through after
// STARVE_MAX consecutive refused cycles. Requests are decoded into word
// address, byte enables and lane-replicated data, and the 1-cycle RAM read
// latency is tracked so the extended load result goes back to its issuer.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic [31:0]           c_addr,
    input  logic                  c_we,
    input  logic [1:0]            c_size,
    input  logic                  c_unsigned,
    input  logic [31:0]           c_wdata,
    output logic                  c_rsp_valid,
    output logic [31:0]           c_rdata,
    output logic                  c_err,

    input  logic                  g_valid,
    output logic                  g_ready,
    input  logic [31:0]           g_addr,
    input  logic                  g_we,
    input  logic [1:0]            g_size,
    input  logic                  g_unsigned,
    input  logic [31:0]           g_wdata,
    output logic                  g_rsp_valid,
    output logic [31:0]           g_rdata,
    output logic                  g_err,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    logic [7:0]            starve_cnt;
    logic                  force_g;
    logic                  grant_c;
    logic                  grant_g;
    logic                  granted;

    logic [31:0]           sel_addr;
    logic                  sel_we;
    mem_size_t             sel_size;
    logic                  sel_uns;
    logic [31:0]           sel_wdata;
    logic [1:0]            sel_off;
    logic                  sel_err;
    logic [ADDR_WIDTH-1:0] word_addr;

    logic                  store_en;
    logic [3:0]            store_be;
    logic [31:0]           store_data;

    logic [ADDR_WIDTH-1:0] held_addr;
    logic [31:0]           held_wdata;

    rsp_ctx_t              new_ctx;
    rsp_ctx_t              ctx;
    logic                  rsp_pending;
    logic                  rsp_live;
    logic                  load_en;
    logic [3:0]            load_be;
    logic [31:0]           load_data;

    // Per-cycle grant: a starved G wins, otherwise C first, then G; nothing while in reset.
    always_comb begin
        force_g = (starve_cnt == 8'(STARVE_MAX));
        grant_g = !reset && g_valid && (force_g || !c_valid);
        grant_c = !reset && c_valid && !grant_g;
        granted = grant_c || grant_g;
    end

    assign c_ready = grant_c;
    assign g_ready = grant_g;

    // Count consecutive cycles G waited without service; any service or withdrawal restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!g_valid || grant_g) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != 8'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Pick the granted request and classify it; C's fields are the idle default.
    always_comb begin
        sel_addr  = grant_g ? g_addr     : c_addr;
        sel_we    = grant_g ? g_we       : c_we;
        sel_size  = mem_size_t'(grant_g ? g_size : c_size);
        sel_uns   = grant_g ? g_unsigned : c_unsigned;
        sel_wdata = grant_g ? g_wdata    : c_wdata;
        sel_off   = sel_addr[1:0];
        word_addr = sel_addr[ADDR_WIDTH+1:2];
        sel_err   = (sel_size == SZ_BAD)
                 || is_misaligned(sel_size, sel_off)
                 || (|sel_addr[31:ADDR_WIDTH+2]);
        store_en  = granted && sel_we && !sel_err;
    end

    dmem_lane_align u_store_align (
        .load     (1'b0),
        .enable   (store_en),
        .size     (sel_size),
        .off      (sel_off),
        .uns      (sel_uns),
        .data_in  (sel_wdata),
        .be       (store_be),
        .data_out (store_data)
    );

    // Remember the last presented address/data so the RAM port stays quiet on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_addr  <= '0;
            held_wdata <= '0;
        end else if (granted) begin
            held_addr  <= word_addr;
            held_wdata <= store_data;
        end
    end

    assign ram_addr  = granted ? word_addr  : held_addr;
    assign ram_wdata = granted ? store_data : held_wdata;
    assign ram_we    = store_en;
    assign ram_be    = store_be;

    // Bundle what the response stage needs about the request granted this cycle.
    always_comb begin
        new_ctx       = '0;
        new_ctx.owner = grant_g ? OWNER_G : OWNER_C;
        new_ctx.we    = sel_we;
        new_ctx.size  = sel_size;
        new_ctx.uns   = sel_uns;
        new_ctx.off   = sel_off;
        new_ctx.err   = sel_err;
    end

    // Carry the request context across the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pending <= 1'b0;
            ctx         <= '0;
        end else begin
            rsp_pending <= granted;
            if (granted) begin
                ctx <= new_ctx;
            end
        end
    end

    assign rsp_live = rsp_pending && !reset;
    assign load_en  = rsp_live && !ctx.we && !ctx.err;

    dmem_lane_align u_load_align (
        .load     (1'b1),
        .enable   (load_en),
        .size     (ctx.size),
        .off      (ctx.off),
        .uns      (ctx.uns),
        .data_in  (ram_rdata),
        .be       (load_be),
        .data_out (load_data)
    );

    // Route the response to its owner only; stores and errors return zero data.
    always_comb begin
        c_rsp_valid = 1'b0;
        c_err       = 1'b0;
        c_rdata     = '0;
        g_rsp_valid = 1'b0;
        g_err       = 1'b0;
        g_rdata     = '0;
        if (rsp_live) begin
            if (ctx.owner == OWNER_C) begin
                c_rsp_valid = 1'b1;
                c_err       = ctx.err;
                c_rdata     = (|load_be) ? load_data : 32'd0;
            end else begin
                g_rsp_valid = 1'b1;
                g_err       = ctx.err;
                g_rdata     = (|load_be) ? load_data : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a small RAM model on the data
// port, a byte-level reference memory, directed cases, then random traffic.
module tb_dmem_port_arbiter;

    localparam int AW   = 15;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_valid, c_ready, c_we, c_unsigned, c_rsp_valid, c_err;
    logic [31:0]   c_addr, c_wdata, c_rdata;
    logic [1:0]    c_size;
    logic          g_valid, g_ready, g_we, g_unsigned, g_rsp_valid, g_err;
    logic [31:0]   g_addr, g_wdata, g_rdata;
    logic [1:0]    g_size;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   ram [0:63];
    logic          load_en;
    logic [5:0]    load_idx;
    logic [31:0]   load_val;

    logic [7:0]    ref_mem [0:255];
    int            starve;
    bit            pend_v;
    bit            pend_port;
    bit            pend_err;
    logic [31:0]   pend_data;
    bit            have_last;
    logic [AW-1:0] last_addr;

    int            compared;
    int            mismatched;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_we(c_we),
        .c_size(c_size), .c_unsigned(c_unsigned), .c_wdata(c_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_err(c_err),
        .g_valid(g_valid), .g_ready(g_ready), .g_addr(g_addr), .g_we(g_we),
        .g_size(g_size), .g_unsigned(g_unsigned), .g_wdata(g_wdata),
        .g_rsp_valid(g_rsp_valid), .g_rdata(g_rdata), .g_err(g_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: byte-enabled write, registered read, plus a preload port.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_idx] <= load_val;
        end else if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) ram[ram_addr[5:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_rdata <= ram[ram_addr[5:0]];
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit req_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        if ((a >> (AW + 2)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[8'(a[7:0] + i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic apply_stimulus(
        input logic r,
        input logic cv, input logic [31:0] ca, input logic cwe, input logic [1:0] csz,
        input logic cu, input logic [31:0] cwd,
        input logic gv, input logic [31:0] ga, input logic gwe, input logic [1:0] gsz,
        input logic gu, input logic [31:0] gwd);
        reset = r;
        c_valid = cv; c_addr = ca; c_we = cwe; c_size = csz; c_unsigned = cu; c_wdata = cwd;
        g_valid = gv; g_addr = ga; g_we = gwe; g_size = gsz; g_unsigned = gu; g_wdata = gwd;
    endtask

    // Check the current cycle against the reference, then advance the reference.
    task automatic model_cycle();
        bit gc, gg, e, rv, wr;
        logic [31:0] a, wd, exp_wd;
        logic        we, uns;
        logic [1:0]  sz;
        logic [3:0]  mask;
        int          n;
        gc = 1'b0;
        gg = 1'b0;
        if (!reset) begin
            gg = g_valid && ((starve == SMAX) || !c_valid);
            gc = c_valid && !gg;
        end
        check_output("c_ready", 32'(c_ready), 32'(gc));
        check_output("g_ready", 32'(g_ready), 32'(gg));

        rv = pend_v && !reset;
        check_output("c_rsp_valid", 32'(c_rsp_valid), 32'(rv && pend_port == 1'b0));
        check_output("g_rsp_valid", 32'(g_rsp_valid), 32'(rv && pend_port == 1'b1));
        check_output("c_err", 32'(c_err), 32'(rv && pend_port == 1'b0 && pend_err));
        check_output("g_err", 32'(g_err), 32'(rv && pend_port == 1'b1 && pend_err));
        check_output("c_rdata", c_rdata, (rv && pend_port == 1'b0) ? pend_data : 32'd0);
        check_output("g_rdata", g_rdata, (rv && pend_port == 1'b1) ? pend_data : 32'd0);

        a   = gg ? g_addr : c_addr;
        we  = gg ? g_we : c_we;
        sz  = gg ? g_size : c_size;
        uns = gg ? g_unsigned : c_unsigned;
        wd  = gg ? g_wdata : c_wdata;
        e   = req_err(a, sz);
        wr  = (gc || gg) && we && !e;
        n   = 1 << sz;
        mask = 4'(((1 << n) - 1) << a[1:0]);
        if (gc || gg) begin
            check_output("ram_addr", 32'(ram_addr), 32'(a[AW+1:2]));
            check_output("ram_we", 32'(ram_we), 32'(wr));
            if (we || e) check_output("ram_be", 32'(ram_be), wr ? 32'(mask) : 32'd0);
            if (wr) begin
                exp_wd = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
                check_output("ram_wdata", ram_wdata, exp_wd);
            end
        end else begin
            check_output("idle_ram_we", 32'(ram_we), 32'd0);
            check_output("idle_ram_be", 32'(ram_be), 32'd0);
            if (have_last) check_output("idle_ram_addr_hold", 32'(ram_addr), 32'(last_addr));
        end

        pend_v = gc || gg;
        if (gc || gg) begin
            pend_port = gg;
            pend_err  = e;
            pend_data = (we || e) ? 32'd0 : ref_load(a, sz, uns);
            if (wr)
                for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + i)] = wd[8*i +: 8];
            have_last = 1'b1;
            last_addr = a[AW+1:2];
        end
        if (reset) have_last = 1'b0;
        if (reset || !g_valid || gg) starve = 0;
        else if (starve < SMAX) starve++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] rand_size();
        int r;
        r = int'($urandom_range(0, 15));
        return (r == 15) ? 2'd3 : 2'(r % 3);
    endfunction

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        int r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, 255));
        if (r == 0) return 32'h0002_0000 | a;
        if (r == 1) return 32'hF000_0000 | a;
        if (r > 3 && sz != 2'd3) a = a & ~(32'((1 << sz) - 1));
        return a;
    endfunction

    initial begin
        logic [31:0] v;
        compared   = 0;
        mismatched = 0;
        starve     = 0;
        pend_v     = 1'b0;
        pend_port  = 1'b0;
        pend_err   = 1'b0;
        pend_data  = 32'd0;
        have_last  = 1'b0;
        last_addr  = '0;
        load_en    = 1'b0;
        load_idx   = '0;
        load_val   = '0;
        apply_stimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Preload RAM and reference memory while reset is held.
        for (int w = 0; w < 64; w++) begin
            v = (w == 0) ? 32'h8899_AABB : (w == 1) ? 32'h1122_3344 : $urandom;
            load_en  = 1'b1;
            load_idx = 6'(w);
            load_val = v;
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = v[8*i +: 8];
            run_cycle();
        end
        load_en = 1'b0;
        apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();

        // Byte/half loads from word 0.
        apply_stimulus(1'b0, 1, 32'h2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_lb_signed", c_rdata, 32'hFFFF_FF99);
        apply_stimulus(1'b0, 1, 32'h2, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_lb_unsigned", c_rdata, 32'h0000_0099);
        apply_stimulus(1'b0, 1, 32'h2, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_lh_signed", c_rdata, 32'hFFFF_8899);

        // Byte store to 0x7 then word readback.
        apply_stimulus(1'b0, 1, 32'h7, 1, 2'd0, 0, 32'h0000_00A5, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("plan_sb_addr", 32'(ram_addr), 32'd1);
        check_output("plan_sb_be", 32'(ram_be), 32'b1000);
        check_output("plan_sb_wdata", ram_wdata, 32'hA5A5_A5A5);
        check_output("plan_sb_we", 32'(ram_we), 32'd1);
        run_cycle();
        apply_stimulus(1'b0, 1, 32'h4, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_lw_after_sb", c_rdata, 32'hA522_3344);

        // Misaligned G half load and misaligned C word store.
        apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0, 2'd1, 0, 0);
        #1;
        check_output("plan_mis_g_ready", 32'(g_ready), 32'd1);
        run_cycle();
        check_output("plan_mis_g_err", 32'(g_err), 32'd1);
        check_output("plan_mis_g_rdata", g_rdata, 32'd0);
        apply_stimulus(1'b0, 1, 32'h2, 1, 2'd2, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("plan_mis_c_we", 32'(ram_we), 32'd0);
        run_cycle();
        check_output("plan_mis_c_err", 32'(c_err), 32'd1);
        apply_stimulus(1'b0, 1, 32'h0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_word0_unchanged", c_rdata, 32'h8899_AABB);

        // Out-of-range store.
        apply_stimulus(1'b0, 1, 32'h0002_0000, 1, 2'd2, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("plan_range_we", 32'(ram_we), 32'd0);
        run_cycle();
        check_output("plan_range_err", 32'(c_err), 32'd1);

        // Both ports continuously valid: G forced through on the ninth cycle.
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(1'b0, 1, 32'(4 * i), 0, 2'd2, 0, 0,
                           1, 32'(4 * (i + 20)), 0, 2'd2, 0, 0);
            #1;
            check_output("plan_starve_g_ready", 32'(g_ready), 32'(i == 9));
            run_cycle();
        end

        // Reset in the same cycle as a C load.
        apply_stimulus(1'b1, 1, 32'h0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("plan_reset_c_ready", 32'(c_ready), 32'd0);
        run_cycle();
        apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("plan_reset_no_rsp", 32'(c_rsp_valid), 32'd0);
        run_cycle();
        apply_stimulus(1'b0, 1, 32'h0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        check_output("plan_post_reset_rsp", 32'(c_rsp_valid), 32'd1);
        check_output("plan_post_reset_data", c_rdata, 32'h0000_00BB);

        // Random mixed traffic against the reference model.
        for (int k = 0; k < 800; k++) begin
            logic [1:0] cs, gs;
            cs = rand_size();
            gs = rand_size();
            apply_stimulus($urandom_range(0, 63) == 0,
                           $urandom_range(0, 9) < 7, rand_addr(cs), 1'($urandom), cs,
                           1'($urandom), $urandom,
                           $urandom_range(0, 9) < 6, rand_addr(gs), 1'($urandom), gs,
                           1'($urandom), $urandom);
            run_cycle();
        end

        apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
